dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Sequential data-memory controller between the core's load/store execution units and the single-port synchronous data RAM. Accepts one load or store request at a time over a valid/ready handshake and sequences the RAM read, byte/half-word read-modify-write and write cycles. Returns a sign- or zero-extended load result or a store completion on a one-cycle response pulse. This moves the byte-merge out of the store path and into a registered state machine, so a store needs no combinational RAM read-back.

## Interface
- AW, 8, RAM word-address width (2^AW words)
- iCLK  in  1  clock, all state on rising edge
- iRST_N  in  1  reset, asynchronous, active-low
- iREQ_VALID  in  1  request valid
- oREQ_READY  out  1  controller idle, request accepted when VALID&&READY at an edge
- iREQ_WR  in  1  1 = store, 0 = load
- iFUNC3  in  3  RV32I funct3 of the load/store
- iADDR  in  32  byte address (rs1 + imm)
- iWDATA  in  32  store data (rs2)
- oRSP_VALID  out  1  one-cycle completion pulse
- oRSP_DATA  out  32  load result (0 for stores/errors)
- oRSP_ERR  out  1  request rejected, qualified by oRSP_VALID
- oRAM_CE, oRAM_RD, oRAM_WR  out  1  RAM strobes
- oRAM_ADDR  out  AW  word address = iADDR[AW+1:2], upper bits ignored
- oRAM_DATA  out  32  write word
- iRAM_DATA  in  32  read word, valid the cycle after a RD cycle

## Operation
- States: IDLE, RD, WAIT, WR, RSP. oREQ_READY = (state==IDLE).
- Acceptance latches WR, FUNC3, ADDR[1:0], word address and WDATA into request registers.
- Transitions from IDLE on acceptance:
  - Illegal funct3 (load: 3/6/7; store: 3–7) -> RSP with ERR=1, no RAM access.
  - SW -> WR.
  - All other legal requests -> RD.
- RD: CE=RD=1 for one cycle -> WAIT.
- WAIT: sample iRAM_DATA.
  - Load: register the extracted result. LB/LH sign-extend, LBU/LHU zero-extend, LW passes through. Byte lane = ADDR[1:0], half lane = ADDR[1]. -> RSP.
  - SB/SH: register the merged word, replacing only the addressed lane with iWDATA[7:0]/[15:0]. -> WR.
- WR: CE=WR=1, oRAM_DATA = merged word (SW: latched iWDATA) -> RSP.
- RSP: oRSP_VALID=1 for one cycle -> IDLE.
- RAM strobes and address are driven from registered state. CE/RD/WR are 0 outside RD/WR.
- Reset: state IDLE. oRSP_VALID, oRSP_ERR, oRSP_DATA, oRAM_* = 0. oREQ_READY = 1.
- Reset mid-operation aborts: no further RAM cycle and no response. A pending RMW write is dropped.
- iREQ_VALID during a non-IDLE state is ignored (not accepted). The requester holds it.

## Timing
- Acceptance edge = cycle 0.
- oRSP_VALID high in cycle 3 for loads, cycle 4 for SB/SH, cycle 2 for SW, cycle 1 for errors.
- Next acceptance earliest in the cycle after RSP. Throughput is one request per latency+1 cycles.
- oRSP_DATA holds its value until the next response. oRSP_ERR is cleared on each non-error response.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined: the following are treated as illegal (ERR response, no RAM access):
  - LH/LHU/SH with ADDR[0]=1
  - LW/SW with ADDR[1:0]!=0
- Undefined: low address bits below the access size are ignored. Half accesses use ADDR[1]. Word accesses use the full word.

## Structure
- Shared package dmem_pkg:
  - State encoding localparams.
  - funct3 constants: LB=0, LH=1, LW=2, LBU=4, LHU=5, SB=0, SH=1, SW=2.
- Sub-module dmem_lane (combinational): inputs word, lane bits, funct3, store data; outputs the extracted load value and the merged store word.

## Test plan
- Reset with iRST_N low mid-stream -> all outputs 0, oREQ_READY=1, no RAM strobe until a new request.
- RAM[4]=0x8899AABB; LB addr 0x13 -> RSP cycle 3, data 0xFFFFFF88; LBU addr 0x12 -> 0x00000099; LH addr 0x10 -> 0xFFFFAABB.
- RAM[2]=0x11223344; SB addr 0x09 data 0xDE -> RD, WAIT, WR with oRAM_DATA 0x1122DE44, oRAM_ADDR 2, RSP cycle 4.
- SH addr 0x0A data 0xCAFE on 0x11223344 -> write 0xCAFE3344. SW addr 0x0C data 0x12345678 -> single WR, RSP cycle 2.
- Store funct3=3 -> RSP cycle 1 with ERR=1, CE never asserted. With DMEM_MISALIGN_TRAP_EN, LW addr 0x02 -> ERR; without it, reads word 0.
- iREQ_VALID held high across back-to-back loads -> second accept only in IDLE after RSP. Reset asserted in WR -> no write and no response.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: FSM states, RV32I
// load/store funct3 codes and the funct3 legality check.
package dmem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WAIT,
        ST_WR,
        ST_RSP
    } dmemStateT;

    localparam logic [2:0] LB  = 3'd0;
    localparam logic [2:0] LH  = 3'd1;
    localparam logic [2:0] LW  = 3'd2;
    localparam logic [2:0] LBU = 3'd4;
    localparam logic [2:0] LHU = 3'd5;
    localparam logic [2:0] SB  = 3'd0;
    localparam logic [2:0] SH  = 3'd1;
    localparam logic [2:0] SW  = 3'd2;

    function automatic logic funcLegal(input logic isWr, input logic [2:0] func3);
        logic legal;
        if (isWr)
            legal = (func3 == SB) || (func3 == SH) || (func3 == SW);
        else
            legal = (func3 == LB) || (func3 == LH) || (func3 == LW) ||
                    (func3 == LBU) || (func3 == LHU);
        return legal;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response handshake and RAM port bundle of dmem_ctrl; signal names
// keep the controller's original port names.
interface dmem_if #(parameter int unsigned AW = 8);
    logic          iREQ_VALID;
    logic          oREQ_READY;
    logic          iREQ_WR;
    logic [2:0]    iFUNC3;
    logic [31:0]   iADDR;
    logic [31:0]   iWDATA;
    logic          oRSP_VALID;
    logic [31:0]   oRSP_DATA;
    logic          oRSP_ERR;
    logic          oRAM_CE;
    logic          oRAM_RD;
    logic          oRAM_WR;
    logic [AW-1:0] oRAM_ADDR;
    logic [31:0]   oRAM_DATA;
    logic [31:0]   iRAM_DATA;

    modport slave (
        input  iREQ_VALID, iREQ_WR, iFUNC3, iADDR, iWDATA, iRAM_DATA,
        output oREQ_READY, oRSP_VALID, oRSP_DATA, oRSP_ERR,
               oRAM_CE, oRAM_RD, oRAM_WR, oRAM_ADDR, oRAM_DATA
    );

    modport master (
        output iREQ_VALID, iREQ_WR, iFUNC3, iADDR, iWDATA, iRAM_DATA,
        input  oREQ_READY, oRSP_VALID, oRSP_DATA, oRSP_ERR,
               oRAM_CE, oRAM_RD, oRAM_WR, oRAM_ADDR, oRAM_DATA
    );
endinterface

// File: rtl/dmem_lane.sv
// Byte/half-word lane logic: extracts and extends a load value from a RAM
// word, and merges store data into the addressed lane for read-modify-write.
module dmem_lane
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [2:0]  func3,
    input  logic [31:0] storeData,
    output logic [31:0] loadVal,
    output logic [31:0] mergedWord
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    always_comb begin
        byteSel = word[{lane, 3'b000} +: 8];
        halfSel = lane[1] ? word[31:16] : word[15:0];

        loadVal = '0;
        case (func3)
            LB:      loadVal = {{24{byteSel[7]}}, byteSel};
            LH:      loadVal = {{16{halfSel[15]}}, halfSel};
            LW:      loadVal = word;
            LBU:     loadVal = {24'd0, byteSel};
            LHU:     loadVal = {16'd0, halfSel};
            default: loadVal = '0;
        endcase

        mergedWord = word;
        case (func3)
            SB: mergedWord[{lane, 3'b000} +: 8] = storeData[7:0];
            SH: begin
                if (lane[1])
                    mergedWord[31:16] = storeData[15:0];
                else
                    mergedWord[15:0] = storeData[15:0];
            end
            default: mergedWord = storeData;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Sequential data-memory controller: one load/store at a time, RAM read,
// byte/half read-modify-write and write cycles. Optional macro
// DMEM_MISALIGN_TRAP_EN rejects misaligned half/word accesses.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned AW = 8
) (
    input logic   iCLK,
    input logic   iRST_N,
    dmem_if.slave bus
);

    dmemStateT     state, nextState;
    logic          reqWr;
    logic [2:0]    reqFunc3;
    logic [1:0]    reqLane;
    logic [AW-1:0] reqWordAddr;
    logic [31:0]   wordReg;
    logic [31:0]   rspData;
    logic          rspErr;
    logic          accept;
    logic          reqOk;
    logic [31:0]   loadVal;
    logic [31:0]   mergedWord;
    logic [31-AW-2:0] unusedAddrBits;

    assign unusedAddrBits = bus.iADDR[31:AW+2];
    assign accept = bus.iREQ_VALID && (state == ST_IDLE);

    always_comb begin
        reqOk = funcLegal(bus.iREQ_WR, bus.iFUNC3);
`ifdef DMEM_MISALIGN_TRAP_EN
        if ((bus.iFUNC3[1:0] == 2'b01) && bus.iADDR[0])
            reqOk = 1'b0;
        if ((bus.iFUNC3[1:0] == 2'b10) && (bus.iADDR[1:0] != 2'b00))
            reqOk = 1'b0;
`endif
    end

    // wordReg holds store data until WAIT replaces it with the merged word
    dmem_lane uLane (
        .word       (bus.iRAM_DATA),
        .lane       (reqLane),
        .func3      (reqFunc3),
        .storeData  (wordReg),
        .loadVal    (loadVal),
        .mergedWord (mergedWord)
    );

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N)
            state <= ST_IDLE;
        else
            state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (!reqOk)
                        nextState = ST_RSP;
                    else if (bus.iREQ_WR && (bus.iFUNC3 == SW))
                        nextState = ST_WR;
                    else
                        nextState = ST_RD;
                end
            end
            ST_RD:   nextState = ST_WAIT;
            ST_WAIT: nextState = reqWr ? ST_WR : ST_RSP;
            ST_WR:   nextState = ST_RSP;
            ST_RSP:  nextState = ST_IDLE;
            default: nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            reqWr       <= 1'b0;
            reqFunc3    <= '0;
            reqLane     <= '0;
            reqWordAddr <= '0;
            wordReg     <= '0;
            rspData     <= '0;
            rspErr      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        reqWr       <= bus.iREQ_WR;
                        reqFunc3    <= bus.iFUNC3;
                        reqLane     <= bus.iADDR[1:0];
                        reqWordAddr <= bus.iADDR[AW+1:2];
                        wordReg     <= bus.iWDATA;
                        if (!reqOk) begin
                            rspData <= '0;
                            rspErr  <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (reqWr) begin
                        wordReg <= mergedWord;
                    end else begin
                        rspData <= loadVal;
                        rspErr  <= 1'b0;
                    end
                end
                ST_WR: begin
                    rspData <= '0;
                    rspErr  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.oREQ_READY = (state == ST_IDLE);
    assign bus.oRSP_VALID = (state == ST_RSP);
    assign bus.oRSP_DATA  = rspData;
    assign bus.oRSP_ERR   = rspErr;
    assign bus.oRAM_CE    = (state == ST_RD) || (state == ST_WR);
    assign bus.oRAM_RD    = (state == ST_RD);
    assign bus.oRAM_WR    = (state == ST_WR);
    assign bus.oRAM_ADDR  = reqWordAddr;
    assign bus.oRAM_DATA  = wordReg;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: directed loads/stores against a RAM model,
// expected responses and RAM writes queued at issue, checked by monitors.
module tb_dmem_ctrl;
    import dmem_pkg::*;

    localparam int unsigned AW = 8;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int unsigned acc;
        int unsigned lat;
        int unsigned id;
    } rspExpT;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wrExpT;

    logic        iCLK = 1'b0;
    logic        iRST_N = 1'b0;
    logic [31:0] mem [0:(2**AW)-1];
    logic [31:0] ramQ = '0;
    int unsigned cycCnt = 0;
    int unsigned ceCycles = 0;
    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned nextId = 0;
    rspExpT      rspQ[$];
    wrExpT       wrQ[$];
    rspExpT      curRsp;
    wrExpT       curWr;

    dmem_if #(.AW(AW)) bus ();

    dmem_ctrl #(.AW(AW)) dut (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .bus    (bus)
    );

    always #5 iCLK = ~iCLK;

    always @(posedge iCLK) begin
        cycCnt <= cycCnt + 1;
        if (bus.oRAM_CE && bus.oRAM_RD)
            ramQ <= mem[bus.oRAM_ADDR];
        if (bus.oRAM_CE && bus.oRAM_WR)
            mem[bus.oRAM_ADDR] <= bus.oRAM_DATA;
    end
    assign bus.iRAM_DATA = ramQ;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // response monitor
    always @(negedge iCLK) begin
        if (bus.oRAM_CE)
            ceCycles++;
        if (bus.oRSP_VALID) begin
            if (rspQ.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected response: data 0x%08h err %0d", bus.oRSP_DATA, bus.oRSP_ERR);
            end else begin
                curRsp = rspQ.pop_front();
                check($sformatf("rsp%0d data", curRsp.id), bus.oRSP_DATA, curRsp.data);
                check($sformatf("rsp%0d err", curRsp.id), {31'd0, bus.oRSP_ERR}, {31'd0, curRsp.err});
                check($sformatf("rsp%0d latency", curRsp.id), cycCnt - curRsp.acc + 1, curRsp.lat);
            end
        end
    end

    // RAM write monitor
    always @(negedge iCLK) begin
        if (bus.oRAM_CE && bus.oRAM_WR) begin
            if (wrQ.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected RAM write: addr %0d data 0x%08h", bus.oRAM_ADDR, bus.oRAM_DATA);
            end else begin
                curWr = wrQ.pop_front();
                check("ram write addr", {24'd0, bus.oRAM_ADDR}, {24'd0, curWr.addr});
                check("ram write data", bus.oRAM_DATA, curWr.data);
            end
        end
    end

    // Called on a negedge; expLat==0 issues without expecting a response.
    task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] expData, input logic expErr,
                         input int unsigned expLat, input bit hold, output int unsigned accCyc);
        int unsigned guard = 0;
        bus.iREQ_VALID = 1'b1;
        bus.iREQ_WR    = wr;
        bus.iFUNC3     = f3;
        bus.iADDR      = addr;
        bus.iWDATA     = wdata;
        accCyc = 0;
        while (!bus.oREQ_READY && guard < 50) begin
            @(negedge iCLK);
            guard++;
        end
        if (guard >= 50) begin
            vectors++;
            miscompares++;
            $display("FAIL accept timeout: ready 0, required 1");
            bus.iREQ_VALID = 1'b0;
        end else begin
            accCyc = cycCnt + 1;
            if (expLat != 0) begin
                rspQ.push_back('{data: expData, err: expErr, acc: accCyc, lat: expLat, id: nextId});
                nextId++;
            end
            @(negedge iCLK);
            if (!hold)
                bus.iREQ_VALID = 1'b0;
        end
    endtask

    task automatic drain();
        int unsigned guard = 0;
        while ((rspQ.size() != 0 || wrQ.size() != 0 || !bus.oREQ_READY) && guard < 40) begin
            @(negedge iCLK);
            guard++;
        end
        if (guard >= 40) begin
            vectors++;
            miscompares++;
            $display("FAIL drain timeout: %0d responses and %0d writes outstanding, required 0",
                     rspQ.size(), wrQ.size());
            rspQ.delete();
            wrQ.delete();
        end
    endtask

    task automatic checkResetState(input string tag);
        check({tag, " ready"}, {31'd0, bus.oREQ_READY}, 32'd1);
        check({tag, " rsp valid/err"}, {30'd0, bus.oRSP_VALID, bus.oRSP_ERR}, 32'd0);
        check({tag, " rsp data"}, bus.oRSP_DATA, 32'd0);
        check({tag, " ram strobes"}, {29'd0, bus.oRAM_CE, bus.oRAM_RD, bus.oRAM_WR}, 32'd0);
        check({tag, " ram addr"}, {24'd0, bus.oRAM_ADDR}, 32'd0);
        check({tag, " ram data"}, bus.oRAM_DATA, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned acc1, acc2, ce0, guard;
        for (int i = 0; i < 2**AW; i++)
            mem[i] = '0;
        mem[0] = 32'hA5A50001;
        mem[2] = 32'h11223344;
        mem[4] = 32'h8899AABB;
        bus.iREQ_VALID = 1'b0;
        bus.iREQ_WR    = 1'b0;
        bus.iFUNC3     = '0;
        bus.iADDR      = '0;
        bus.iWDATA     = '0;

        repeat (3) @(negedge iCLK);
        checkResetState("reset");
        iRST_N = 1'b1;
        @(negedge iCLK);

        // loads from word 4 = 0x8899AABB
        issue(1'b0, LB,  32'h13, '0, 32'hFFFFFF88, 1'b0, 3, 1'b0, acc1);
        drain();
        issue(1'b0, LBU, 32'h12, '0, 32'h00000099, 1'b0, 3, 1'b0, acc1);
        drain();
        issue(1'b0, LH,  32'h10, '0, 32'hFFFFAABB, 1'b0, 3, 1'b0, acc1);
        drain();
        issue(1'b0, LHU, 32'h12, '0, 32'h00008899, 1'b0, 3, 1'b0, acc1);
        drain();
        issue(1'b0, LW,  32'h10, '0, 32'h8899AABB, 1'b0, 3, 1'b0, acc1);
        drain();
        repeat (3) @(negedge iCLK);
        check("rsp data held while idle", bus.oRSP_DATA, 32'h8899AABB);

        // stores: byte and half read-modify-write, full word direct
        wrQ.push_back('{addr: 8'd2, data: 32'h1122DE44});
        issue(1'b1, SB, 32'h09, 32'hFFFFFFDE, 32'h0, 1'b0, 4, 1'b0, acc1);
        drain();
        mem[2] = 32'h11223344;
        wrQ.push_back('{addr: 8'd2, data: 32'hCAFE3344});
        issue(1'b1, SH, 32'h0A, 32'hFFFFCAFE, 32'h0, 1'b0, 4, 1'b0, acc1);
        drain();
        wrQ.push_back('{addr: 8'd3, data: 32'h12345678});
        issue(1'b1, SW, 32'h0C, 32'h12345678, 32'h0, 1'b0, 2, 1'b0, acc1);
        drain();
        issue(1'b0, LW, 32'h0C, '0, 32'h12345678, 1'b0, 3, 1'b0, acc1);
        drain();

        // illegal funct3: immediate error, no RAM access
        ce0 = ceCycles;
        issue(1'b1, 3'd3, 32'h20, 32'hDEADBEEF, 32'h0, 1'b1, 1, 1'b0, acc1);
        drain();
        issue(1'b0, 3'd6, 32'h20, '0, 32'h0, 1'b1, 1, 1'b0, acc1);
        drain();
        check("ce cycles on errors", ceCycles - ce0, 32'd0);

        // misaligned word load
`ifdef DMEM_MISALIGN_TRAP_EN
        issue(1'b0, LW, 32'h02, '0, 32'h0, 1'b1, 1, 1'b0, acc1);
`else
        issue(1'b0, LW, 32'h02, '0, 32'hA5A50001, 1'b0, 3, 1'b0, acc1);
`endif
        drain();

        // valid held high: second request waits until after the response
        issue(1'b0, LB,  32'h11, '0, 32'hFFFFFFAA, 1'b0, 3, 1'b1, acc1);
        issue(1'b0, LHU, 32'h10, '0, 32'h0000AABB, 1'b0, 3, 1'b0, acc2);
        drain();
        check("back-to-back accept gap", acc2 - acc1, 32'd4);

        // reset while the RMW write is on the bus: write and response dropped
        issue(1'b1, SB, 32'h08, 32'h00000077, 32'h0, 1'b0, 0, 1'b0, acc1);
        guard = 0;
        do begin
            @(posedge iCLK);
            #1;
            guard++;
        end while (!bus.oRAM_WR && guard < 10);
        check("reached WR state", {31'd0, bus.oRAM_WR}, 32'd1);
        iRST_N = 1'b0;
        @(negedge iCLK);
        checkResetState("mid-op reset");
        @(negedge iCLK);
        iRST_N = 1'b1;
        ce0 = ceCycles;
        repeat (6) @(negedge iCLK);
        check("ce cycles after reset", ceCycles - ce0, 32'd0);
        check("ram word 2 after aborted write", mem[2], 32'hCAFE3344);

        drain();
        check("outstanding responses", rspQ.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
